// File: rtl/dbus_pkg.sv
// Data-bus types shared by every master and slave on the core data bus.
// Requests are held stable while valid; responses split address and data acceptance.
package dbus_pkg;

   typedef enum logic [1:0] {
      MSIZE1 = 2'd0,
      MSIZE2 = 2'd1,
      MSIZE4 = 2'd2
   } msize_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] addr;
      msize_t      size;
      logic [3:0]  strobe;
      logic [31:0] data;
   } dbus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [31:0] data;
   } dbus_resp_t;

endpackage

// File: rtl/mem_pkg.sv
// Types for the memory pipeline stage: operation codes, FSM states, and bus aliases.
// align_addr() clears address low bits to the natural alignment of the access size.
package mem_pkg;

   typedef dbus_pkg::msize_t     msize_t;
   typedef dbus_pkg::dbus_req_t  dbus_req_t;
   typedef dbus_pkg::dbus_resp_t dbus_resp_t;

   typedef enum logic [1:0] {
      MOP_NONE  = 2'd0,
      MOP_LOAD  = 2'd1,
      MOP_STORE = 2'd2
   } mem_op_t;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT
   } mem_state_t;

   function automatic logic [31:0] align_addr(input logic [31:0] a, input msize_t s);
      case (s)
         dbus_pkg::MSIZE2: return {a[31:1], 1'b0};
         dbus_pkg::MSIZE4: return {a[31:2], 2'b00};
         default:          return a;
      endcase
   endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane helper: store strobe and data replication, load shift and sign/zero extension.
// Purely combinational; used once on the request side and once on the response side.
module mem_align
   import mem_pkg::*;
(
   input  msize_t      size,
   input  logic        sgn,
   input  logic [1:0]  lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  strobe,
   output logic [31:0] wrep,
   output logic [31:0] rext
);

   logic [31:0] shifted;

   always_comb begin
      strobe  = 4'hf;
      wrep    = wdata;
      shifted = rdata >> {lo, 3'b000};
      rext    = shifted;
      case (size)
         dbus_pkg::MSIZE1: begin
            strobe = 4'b0001 << lo;
            wrep   = {4{wdata[7:0]}};
            rext   = {{24{sgn & shifted[7]}}, shifted[7:0]};
         end
         dbus_pkg::MSIZE2: begin
            strobe = 4'b0011 << lo;
            wrep   = {2{wdata[15:0]}};
            rext   = {{16{sgn & shifted[15]}}, shifted[15:0]};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MIPS memory stage: issues loads/stores on dbus, aligns data, registers results for writeback.
// Define MEM_ADDR_EXC_EN to raise AdEL/AdES on misaligned accesses instead of force-aligning.
module mem_stage_ctrl
   import mem_pkg::*;
#(
   parameter int unsigned REG_AW = 5,
   parameter int unsigned PC_W   = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PC_W-1:0]   in_pc,
   input  mem_op_t           in_op,
   input  msize_t            in_size,
   input  logic              in_signed,
   input  logic [31:0]       in_addr,
   input  logic [31:0]       in_wdata,
   input  logic [REG_AW-1:0] in_regt,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PC_W-1:0]   out_pc,
   output logic              out_wen,
   output logic [REG_AW-1:0] out_regw,
   output logic [31:0]       out_data,
   output logic              out_adel,
   output logic              out_ades,
   output logic [31:0]       out_badvaddr,
   output dbus_req_t         dreq,
   input  dbus_resp_t        dresp
);

   mem_state_t        state, state_nx;
   mem_op_t           lat_op;
   msize_t            lat_size;
   logic              lat_signed;
   logic [31:0]       lat_addr, lat_wdata;
   logic [REG_AW-1:0] lat_regt;
   logic [PC_W-1:0]   lat_pc;

   logic        accept, is_mem, misaligned, done;
   logic [3:0]  req_strobe, unused_rsp_strobe;
   logic [31:0] req_data, rsp_data, unused_rsp_wrep, unused_req_rext;

   assign is_mem = (in_op == MOP_LOAD) || (in_op == MOP_STORE);
   assign accept = in_valid && in_ready;

`ifdef MEM_ADDR_EXC_EN
   assign misaligned = is_mem &&
                       (((in_size == dbus_pkg::MSIZE2) && in_addr[0]) ||
                        ((in_size == dbus_pkg::MSIZE4) && (in_addr[1:0] != 2'b00)));
`else
   assign misaligned = 1'b0;
`endif

   mem_align u_req_align (
      .size(lat_size), .sgn(lat_signed), .lo(lat_addr[1:0]),
      .wdata(lat_wdata), .rdata(32'h0),
      .strobe(req_strobe), .wrep(req_data), .rext(unused_req_rext)
   );

   mem_align u_rsp_align (
      .size(lat_size), .sgn(lat_signed), .lo(lat_addr[1:0]),
      .wdata(32'h0), .rdata(dresp.data),
      .strobe(unused_rsp_strobe), .wrep(unused_rsp_wrep), .rext(rsp_data)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nx;
   end

   // dreq is zero outside REQ so a reset mid-transaction drops it with the state register
   always_comb begin
      state_nx = state;
      in_ready = 1'b0;
      done     = 1'b0;
      dreq     = '0;
      case (state)
         IDLE: begin
            in_ready = !out_valid || out_ready;
            if (in_valid && in_ready && is_mem && !misaligned) state_nx = REQ;
         end
         REQ: begin
            dreq.valid  = 1'b1;
            dreq.addr   = lat_addr;
            dreq.size   = lat_size;
            dreq.strobe = (lat_op == MOP_STORE) ? req_strobe : 4'h0;
            dreq.data   = (lat_op == MOP_STORE) ? req_data : 32'h0;
            if (dresp.addr_ok) begin
               if (dresp.data_ok) begin
                  done     = 1'b1;
                  state_nx = IDLE;
               end else begin
                  state_nx = WAIT;
               end
            end
         end
         WAIT: begin
            if (dresp.data_ok) begin
               done     = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lat_op     <= MOP_NONE;
         lat_size   <= dbus_pkg::MSIZE1;
         lat_signed <= 1'b0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         lat_regt   <= '0;
         lat_pc     <= '0;
      end else if (accept && is_mem && !misaligned) begin
         lat_op     <= in_op;
         lat_size   <= in_size;
         lat_signed <= in_signed;
         lat_addr   <= align_addr(in_addr, in_size);
         lat_wdata  <= in_wdata;
         lat_regt   <= in_regt;
         lat_pc     <= in_pc;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         out_valid <= 1'b0;
         out_pc    <= '0;
         out_wen   <= 1'b0;
         out_regw  <= '0;
         out_data  <= '0;
      end else if (accept && (!is_mem || misaligned)) begin
         out_valid <= 1'b1;
         out_pc    <= in_pc;
         out_wen   <= !is_mem && (in_regt != '0);
         out_regw  <= in_regt;
         out_data  <= is_mem ? 32'h0 : in_addr;
      end else if (done) begin
         out_valid <= 1'b1;
         out_pc    <= lat_pc;
         out_wen   <= (lat_op == MOP_LOAD) && (lat_regt != '0);
         out_regw  <= lat_regt;
         out_data  <= (lat_op == MOP_LOAD) ? rsp_data : 32'h0;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef MEM_ADDR_EXC_EN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         out_adel     <= 1'b0;
         out_ades     <= 1'b0;
         out_badvaddr <= '0;
      end else if (accept) begin
         out_adel     <= misaligned && (in_op == MOP_LOAD);
         out_ades     <= misaligned && (in_op == MOP_STORE);
         out_badvaddr <= misaligned ? in_addr : 32'h0;
      end else if (done) begin
         out_adel     <= 1'b0;
         out_ades     <= 1'b0;
         out_badvaddr <= '0;
      end
   end
`else
   assign out_adel     = 1'b0;
   assign out_ades     = 1'b0;
   assign out_badvaddr = '0;
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed self-checking bench for mem_stage_ctrl with hand-computed expectations.
// Exception cases are exercised when MEM_ADDR_EXC_EN is defined, force-alignment otherwise.
module tb_mem_stage_ctrl;
   import mem_pkg::*;

   logic        clk = 1'b0;
   logic        resetn;
   logic        in_valid, in_ready, in_signed;
   logic [31:0] in_pc, in_addr, in_wdata;
   mem_op_t     in_op;
   msize_t      in_size;
   logic [4:0]  in_regt, out_regw;
   logic        out_valid, out_ready, out_wen, out_adel, out_ades;
   logic [31:0] out_pc, out_data, out_badvaddr;
   dbus_req_t   dreq;
   dbus_resp_t  dresp;

   int unsigned passed = 0;
   int unsigned total  = 0;

   mem_stage_ctrl #(.REG_AW(5), .PC_W(32)) dut (
      .clk(clk), .resetn(resetn),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_op(in_op),
      .in_size(in_size), .in_signed(in_signed), .in_addr(in_addr),
      .in_wdata(in_wdata), .in_regt(in_regt),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_wen(out_wen), .out_regw(out_regw), .out_data(out_data),
      .out_adel(out_adel), .out_ades(out_ades), .out_badvaddr(out_badvaddr),
      .dreq(dreq), .dresp(dresp)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
      else passed++;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents one instruction for exactly one edge; caller ensures in_ready is high.
   task automatic issue(input mem_op_t op, input msize_t sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [4:0] rt, input logic [31:0] pc);
      in_valid = 1'b1; in_op = op; in_size = sz; in_signed = sg;
      in_addr = addr; in_wdata = wd; in_regt = rt; in_pc = pc;
      check("in_ready_before_issue", {31'b0, in_ready}, 32'd1);
      step();
      in_valid = 1'b0;
   endtask

   task automatic respond(input logic [31:0] data);
      dresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: data};
      step();
      dresp = '0;
   endtask

   initial begin
      resetn = 1'b0; in_valid = 1'b0; in_op = MOP_NONE; in_size = dbus_pkg::MSIZE1;
      in_signed = 1'b0; in_addr = '0; in_wdata = '0; in_regt = '0; in_pc = '0;
      out_ready = 1'b1; dresp = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_dreq_valid", {31'b0, dreq.valid}, 32'd0);
      check("rst_dreq_strobe", {28'b0, dreq.strobe}, 32'd0);
      check("rst_out_data", out_data, 32'd0);
      check("rst_in_ready", {31'b0, in_ready}, 32'd1);
      resetn = 1'b1;

      // ALU pass-through, back-to-back
      issue(MOP_NONE, dbus_pkg::MSIZE4, 1'b0, 32'h1234, 32'h0, 5'd8, 32'h100);
      check("alu_valid", {31'b0, out_valid}, 32'd1);
      check("alu_data", out_data, 32'h1234);
      check("alu_wen", {31'b0, out_wen}, 32'd1);
      check("alu_regw", {27'b0, out_regw}, 32'd8);
      check("alu_pc", out_pc, 32'h100);
      issue(MOP_NONE, dbus_pkg::MSIZE4, 1'b0, 32'h55, 32'h0, 5'd0, 32'h104);
      check("alu2_data", out_data, 32'h55);
      check("alu2_wen_r0", {31'b0, out_wen}, 32'd0);
      step();
      check("alu_drain", {31'b0, out_valid}, 32'd0);

      // SB at byte 3
      issue(MOP_STORE, dbus_pkg::MSIZE1, 1'b0, 32'h1003, 32'h0000_00AB, 5'd5, 32'h200);
      check("sb_dreq_valid", {31'b0, dreq.valid}, 32'd1);
      check("sb_strobe", {28'b0, dreq.strobe}, 32'h8);
      check("sb_data", dreq.data, 32'hABAB_ABAB);
      check("sb_addr", dreq.addr, 32'h1003);
      check("sb_in_ready", {31'b0, in_ready}, 32'd0);
      respond(32'h0);
      check("sb_out_valid", {31'b0, out_valid}, 32'd1);
      check("sb_wen", {31'b0, out_wen}, 32'd0);
      check("sb_dreq_drop", {31'b0, dreq.valid}, 32'd0);

      // SH at upper half
      issue(MOP_STORE, dbus_pkg::MSIZE2, 1'b0, 32'h4002, 32'h1234_BEEF, 5'd5, 32'h204);
      check("sh_strobe", {28'b0, dreq.strobe}, 32'hC);
      check("sh_data", dreq.data, 32'hBEEF_BEEF);
      respond(32'h0);

      // LB signed / unsigned at byte 2
      issue(MOP_LOAD, dbus_pkg::MSIZE1, 1'b1, 32'h2002, 32'h0, 5'd9, 32'h300);
      check("lb_addr", dreq.addr, 32'h2002);
      check("lb_size", {30'b0, dreq.size}, {30'b0, dbus_pkg::MSIZE1});
      respond(32'h0080_0000);
      check("lbs_data", out_data, 32'hFFFF_FF80);
      check("lbs_wen", {31'b0, out_wen}, 32'd1);
      check("lbs_regw", {27'b0, out_regw}, 32'd9);
      issue(MOP_LOAD, dbus_pkg::MSIZE1, 1'b0, 32'h2002, 32'h0, 5'd9, 32'h304);
      respond(32'h0080_0000);
      check("lbu_data", out_data, 32'h0000_0080);

      // LH signed at upper half
      issue(MOP_LOAD, dbus_pkg::MSIZE2, 1'b1, 32'h4002, 32'h0, 5'd10, 32'h308);
      respond(32'h8001_0000);
      check("lhs_data", out_data, 32'hFFFF_8001);

      // Bus stall: addr_ok after 3 cycles, data_ok 2 cycles later
      issue(MOP_LOAD, dbus_pkg::MSIZE4, 1'b0, 32'h3000, 32'h0, 5'd11, 32'h400);
      for (int i = 0; i < 3; i++) begin
         check("stall_req_valid", {31'b0, dreq.valid}, 32'd1);
         check("stall_req_addr", dreq.addr, 32'h3000);
         check("stall_in_ready", {31'b0, in_ready}, 32'd0);
         check("stall_out_valid", {31'b0, out_valid}, 32'd0);
         step();
      end
      dresp = '{addr_ok: 1'b1, data_ok: 1'b0, data: 32'hDEAD_DEAD};
      step();
      dresp = '{addr_ok: 1'b0, data_ok: 1'b0, data: 32'h1111_1111};
      check("wait_req_valid", {31'b0, dreq.valid}, 32'd0);
      check("wait_in_ready", {31'b0, in_ready}, 32'd0);
      step();
      check("wait2_out_valid", {31'b0, out_valid}, 32'd0);
      dresp = '{addr_ok: 1'b0, data_ok: 1'b1, data: 32'hCAFE_F00D};
      step();
      dresp = '0;
      check("stall_done_valid", {31'b0, out_valid}, 32'd1);
      check("stall_done_data", out_data, 32'hCAFE_F00D);
      step();
      check("stall_one_pulse", {31'b0, out_valid}, 32'd0);

      // Backpressure for 4 cycles
      out_ready = 1'b0;
      issue(MOP_NONE, dbus_pkg::MSIZE4, 1'b0, 32'h77, 32'h0, 5'd3, 32'h500);
      in_valid = 1'b1; in_op = MOP_NONE; in_addr = 32'h88; in_regt = 5'd4; in_pc = 32'h504;
      for (int i = 0; i < 4; i++) begin
         check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
         check("bp_hold_data", out_data, 32'h77);
         check("bp_in_ready", {31'b0, in_ready}, 32'd0);
         step();
      end
      out_ready = 1'b1;
      #1;
      check("bp_release_ready", {31'b0, in_ready}, 32'd1);
      step();
      in_valid = 1'b0;
      check("bp_next_data", out_data, 32'h88);
      check("bp_next_regw", {27'b0, out_regw}, 32'd4);
      step();

`ifdef MEM_ADDR_EXC_EN
      issue(MOP_LOAD, dbus_pkg::MSIZE4, 1'b0, 32'h5002, 32'h0, 5'd7, 32'h600);
      check("adel_no_req", {31'b0, dreq.valid}, 32'd0);
      check("adel_valid", {31'b0, out_valid}, 32'd1);
      check("adel_flag", {31'b0, out_adel}, 32'd1);
      check("adel_badv", out_badvaddr, 32'h5002);
      check("adel_wen", {31'b0, out_wen}, 32'd0);
      issue(MOP_STORE, dbus_pkg::MSIZE2, 1'b0, 32'h5001, 32'h0, 5'd7, 32'h604);
      check("ades_flag", {31'b0, out_ades}, 32'd1);
      check("ades_adel_clr", {31'b0, out_adel}, 32'd0);
      check("ades_badv", out_badvaddr, 32'h5001);
      step();
`else
      issue(MOP_LOAD, dbus_pkg::MSIZE4, 1'b0, 32'h5002, 32'h0, 5'd7, 32'h600);
      check("lw_forced_align", dreq.addr, 32'h5000);
      respond(32'h0102_0304);
      check("lw_align_data", out_data, 32'h0102_0304);
      check("no_adel", {31'b0, out_adel}, 32'd0);
      check("no_badv", out_badvaddr, 32'h0);
      step();
`endif

      // Reset mid-REQ: dreq.valid drops without a clock edge
      issue(MOP_LOAD, dbus_pkg::MSIZE4, 1'b0, 32'h6000, 32'h0, 5'd2, 32'h700);
      check("rreq_pre_valid", {31'b0, dreq.valid}, 32'd1);
      #2 resetn = 1'b0;
      #1;
      check("rreq_async_drop", {31'b0, dreq.valid}, 32'd0);
      #1 resetn = 1'b1;
      step();

      // Reset mid-WAIT
      issue(MOP_LOAD, dbus_pkg::MSIZE4, 1'b0, 32'h6000, 32'h0, 5'd2, 32'h704);
      dresp = '{addr_ok: 1'b1, data_ok: 1'b0, data: 32'h0};
      step();
      dresp = '0;
      #2 resetn = 1'b0;
      #1;
      check("rwait_dreq", {31'b0, dreq.valid}, 32'd0);
      check("rwait_out_valid", {31'b0, out_valid}, 32'd0);
      check("rwait_in_ready", {31'b0, in_ready}, 32'd1);
      #1 resetn = 1'b1;
      step();
      issue(MOP_NONE, dbus_pkg::MSIZE4, 1'b0, 32'h9999, 32'h0, 5'd1, 32'h800);
      check("post_reset_alu", out_data, 32'h9999);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $display("%0d/%0d checks passed", passed, total + 1);
      $fatal(1);
   end

endmodule
